// File: rtl/chacha_block_core.sv
// Sequential ChaCha block core: four quarterround lanes, one half-round per cycle, feed-forward on exit.
// Optional HChaCha output mode is enabled by defining CHACHA_HCHACHA_EN.
module chacha_block_core #(
    parameter int unsigned ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
`ifdef CHACHA_HCHACHA_EN
    input  logic         hchacha,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream
);

    localparam int unsigned K_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(ROUNDS - 1);

    if ((ROUNDS % 2) != 0 || ROUNDS < 2 || ROUNDS > 254) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be even and within 2..254");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [K_W-1:0] k;
    logic [31:0]    init_w [16];
    logic [31:0]    work_w [16];
    logic [31:0]    load_w [16];
    logic [31:0]    hr_w   [16];
    logic [511:0]   ks_c;
    logic           in_ready_nxt;
    logic           out_valid_nxt;
`ifdef CHACHA_HCHACHA_EN
    logic           hc_q;
`endif

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Returns {a, b, c, d} after one quarterround.
    function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic [31:0] c_i, input logic [31:0] d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Initial state assembled from constants, key, counter and nonce.
    always_comb begin
        load_w[0]  = 32'h61707865;
        load_w[1]  = 32'h3320646e;
        load_w[2]  = 32'h79622d32;
        load_w[3]  = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            load_w[4 + i] = key[32*i +: 32];
        end
        load_w[12] = counter;
        for (int j = 0; j < 3; j++) begin
            load_w[13 + j] = nonce[32*j +: 32];
        end
    end

    // Four parallel lanes; k[0] selects column or diagonal pattern.
    always_comb begin
        hr_w = work_w;
        if (!k[0]) begin
            {hr_w[0], hr_w[4], hr_w[8],  hr_w[12]} = qr(work_w[0], work_w[4], work_w[8],  work_w[12]);
            {hr_w[1], hr_w[5], hr_w[9],  hr_w[13]} = qr(work_w[1], work_w[5], work_w[9],  work_w[13]);
            {hr_w[2], hr_w[6], hr_w[10], hr_w[14]} = qr(work_w[2], work_w[6], work_w[10], work_w[14]);
            {hr_w[3], hr_w[7], hr_w[11], hr_w[15]} = qr(work_w[3], work_w[7], work_w[11], work_w[15]);
        end else begin
            {hr_w[0], hr_w[5], hr_w[10], hr_w[15]} = qr(work_w[0], work_w[5], work_w[10], work_w[15]);
            {hr_w[1], hr_w[6], hr_w[11], hr_w[12]} = qr(work_w[1], work_w[6], work_w[11], work_w[12]);
            {hr_w[2], hr_w[7], hr_w[8],  hr_w[13]} = qr(work_w[2], work_w[7], work_w[8],  work_w[13]);
            {hr_w[3], hr_w[4], hr_w[9],  hr_w[14]} = qr(work_w[3], work_w[4], work_w[9],  work_w[14]);
        end
    end

    // Final output word formation.
    always_comb begin
        ks_c = '0;
        for (int i = 0; i < 16; i++) begin
            ks_c[32*i +: 32] = work_w[i] + init_w[i];
        end
`ifdef CHACHA_HCHACHA_EN
        if (hc_q) begin
            ks_c = '0;
            for (int i = 0; i < 4; i++) begin
                ks_c[32*i +: 32]       = work_w[i];
                ks_c[32*(i + 4) +: 32] = work_w[12 + i];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = S_ROUND;
            S_ROUND: if (k == K_LAST) state_next = S_FINAL;
            S_FINAL: state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the upcoming state.
    always_comb begin
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        case (state_next)
            S_IDLE:  in_ready_nxt  = 1'b1;
            S_DONE:  out_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            keystream <= '0;
            for (int i = 0; i < 16; i++) begin
                init_w[i] <= '0;
                work_w[i] <= '0;
            end
`ifdef CHACHA_HCHACHA_EN
            hc_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        k      <= '0;
                        init_w <= load_w;
                        work_w <= load_w;
`ifdef CHACHA_HCHACHA_EN
                        hc_q   <= hchacha;
`endif
                    end
                end
                S_ROUND: begin
                    work_w <= hr_w;
                    if (k != K_LAST) begin
                        k <= k + K_W'(1);
                    end
                end
                S_FINAL: keystream <= ks_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_core.sv
// Scoreboard bench for chacha_block_core: directed vectors, queue of expected blocks, negedge monitor.
module tb_chacha_block_core;
    parameter int unsigned ROUNDS = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] key;
    logic [31:0]  counter;
    logic [95:0]  nonce;
    logic         hchacha;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] keystream;

    always #5 clk = ~clk;

    chacha_block_core #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .counter   (counter),
        .nonce     (nonce),
`ifdef CHACHA_HCHACHA_EN
        .hchacha   (hchacha),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .keystream (keystream)
    );

    int checks = 0;
    int passed = 0;
    logic [511:0] exp_q [$];

    localparam logic [511:0] RFC_BLOCK = {
        32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
    localparam logic [255:0] HCHACHA_SUBKEY = {
        32'hdcecd326, 32'h13c42ec1, 32'h53a8748a, 32'hd5e4f9a0,
        32'h737d878a, 32'h50420ed3, 32'hfe7bb227, 32'h423b4182};

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Software ChaCha: full double-rounds driven by a quarterround index table.
    function automatic logic [511:0] ref_block(input logic [255:0] kk, input logic [31:0] cc,
                                               input logic [95:0] nn, input bit hc);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [31:0] a, b, c, d;
        logic [511:0] r;
        int idx [8][4];
        idx = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = kk[32*i +: 32];
        s[12] = cc;
        for (int i = 0; i < 3; i++) s[13 + i] = nn[32*i +: 32];
        x = s;
        for (int dr = 0; dr < int'(ROUNDS) / 2; dr++) begin
            for (int q = 0; q < 8; q++) begin
                a = x[idx[q][0]]; b = x[idx[q][1]]; c = x[idx[q][2]]; d = x[idx[q][3]];
                a += b; d ^= a; d = rol(d, 16);
                c += d; b ^= c; b = rol(b, 12);
                a += b; d ^= a; d = rol(d, 8);
                c += d; b ^= c; b = rol(b, 7);
                x[idx[q][0]] = a; x[idx[q][1]] = b; x[idx[q][2]] = c; x[idx[q][3]] = d;
            end
        end
        r = '0;
        if (hc) begin
            for (int i = 0; i < 4; i++) begin
                r[32*i +: 32]       = x[i];
                r[32*(i + 4) +: 32] = x[12 + i];
            end
        end else begin
            for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        end
        return r;
    endfunction

    // Monitor: every completed output handshake pops one expected block.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", keystream, '0);
            end else begin
                check("keystream", keystream, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] cc, input logic [95:0] nn, input bit hc,
                        input bit push, input logic [511:0] exp);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (!in_ready) check("send_timeout", 512'(in_ready), 512'(1));
        counter  = cc;
        nonce    = nn;
        hchacha  = hc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (push) exp_q.push_back(exp);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
    endtask

    logic [95:0]  rfc_nonce;
    logic [511:0] rfc_exp;
    logic [511:0] cap;
    int           n;
    int           t;
    int           hi_cnt;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        hchacha   = 1'b0;
        counter   = '0;
        nonce     = '0;
        for (int b = 0; b < 32; b++) key[8*b +: 8] = 8'(b);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        rfc_exp   = (ROUNDS == 20) ? RFC_BLOCK : ref_block(key, 32'd1, rfc_nonce, 1'b0);

        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", 512'(in_ready), 512'(1));
        check("reset_out_valid", 512'(out_valid), 512'(0));
        check("reset_keystream", keystream, '0);

        // RFC block with latency measurement.
        send(32'd1, rfc_nonce, 1'b0, 1'b1, rfc_exp);
        check("busy_in_ready", 512'(in_ready), 512'(0));
        wait_out(n);
        check("latency_rfc", 512'(n), 512'(ROUNDS + 1));
        tick();
        check("post_hs_in_ready", 512'(in_ready), 512'(1));
        check("post_hs_out_valid", 512'(out_valid), 512'(0));

        // Backpressure: output must hold and new inputs must be ignored.
        out_ready = 1'b0;
        send(32'd1, rfc_nonce, 1'b0, 1'b1, rfc_exp);
        wait_out(n);
        cap = keystream;
        for (int i = 0; i < 10; i++) begin
            counter  = 32'd99;
            in_valid = 1'b1;
            tick();
            check("stall_stable", keystream, cap);
            check("stall_in_ready", 512'({in_ready, out_valid}), 512'(2'b01));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stall_release", 512'({in_ready, out_valid}), 512'(2'b10));
        tick();
        tick();
        check("no_stray_block", 512'({in_ready, out_valid}), 512'(2'b10));

        // Back-to-back: counter 1 then 2 with in_valid held high.
        counter  = 32'd1;
        nonce    = rfc_nonce;
        in_valid = 1'b1;
        tick();
        exp_q.push_back(rfc_exp);
        counter = 32'd2;
        t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        check("accept_interval", 512'(t + 1), 512'(ROUNDS + 3));
        tick();
        in_valid = 1'b0;
        exp_q.push_back(ref_block(key, 32'd2, rfc_nonce, 1'b0));
        wait_out(n);
        check("latency_b2b", 512'(n), 512'(ROUNDS + 1));
        tick();

        // Reset during half-round 7 drops the block.
        send(32'd3, rfc_nonce, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_state", 512'({in_ready, out_valid}), 512'(2'b10));
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) hi_cnt++;
        end
        check("midreset_no_output", 512'(hi_cnt), 512'(0));
        send(32'd5, rfc_nonce, 1'b0, 1'b1, ref_block(key, 32'd5, rfc_nonce, 1'b0));
        wait_out(n);
        check("latency_after_reset", 512'(n), 512'(ROUNDS + 1));
        tick();

`ifdef CHACHA_HCHACHA_EN
        send(32'h09000000, {32'h27594131, 32'h00000000, 32'h4a000000}, 1'b1, 1'b1,
             (ROUNDS == 20) ? {256'd0, HCHACHA_SUBKEY}
                            : ref_block(key, 32'h09000000, {32'h27594131, 32'h00000000, 32'h4a000000}, 1'b1));
        wait_out(n);
        check("latency_hchacha", 512'(n), 512'(ROUNDS + 1));
        tick();
`endif

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            tick();
            t++;
        end
        check("scoreboard_drained", 512'(exp_q.size()), 512'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
